// File: rtl/ysyx_25040118_ibuf.sv
// Fetch-to-decode instruction buffer: DEPTH-entry {pc, inst} FIFO with flush.
// Optional zero-latency empty-path forwarding under YSYX_25040118_IBUF_BYPASS_EN.
module ysyx_25040118_ibuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    output logic [AW:0]   count
);

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] RESET_NOP = 32'h0000_0013;

    logic [63:0] mem [DEPTH];
    logic [AW:0] rptr;
    logic [AW:0] wptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        wr_en;
    logic        rd_en;
    logic [63:0] head;

    assign empty = (rptr == wptr);
    assign full  = (rptr[AW-1:0] == wptr[AW-1:0]) && (rptr[AW] != wptr[AW]);
    assign head  = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;

    // rst gates the handshakes so nothing completes while reset is asserted
    assign in_ready = rst && !full && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

`ifdef YSYX_25040118_IBUF_BYPASS_EN
    logic bypass;
    assign bypass = rst && empty && !flush;

    always_comb begin
        out_valid = rst && !empty && !flush;
        out_pc    = empty ? RESET_PC  : head[63:32];
        out_inst  = empty ? RESET_NOP : head[31:0];
        if (bypass && in_valid) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
    end

    // A forwarded pair consumed in the same cycle never touches storage
    assign wr_en = push && !(bypass && out_ready);
    assign rd_en = pop && !empty;
`else
    assign out_valid = rst && !empty && !flush;
    assign out_pc    = empty ? RESET_PC  : head[63:32];
    assign out_inst  = empty ? RESET_NOP : head[31:0];
    assign wr_en     = push;
    assign rd_en     = pop;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= {in_pc, in_inst};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr <= '0;
            wptr <= '0;
        end else if (flush) begin
            rptr <= wptr;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_25040118_ibuf.sv
// Directed vector bench for ysyx_25040118_ibuf; follows YSYX_25040118_IBUF_BYPASS_EN if defined.
module tb_ysyx_25040118_ibuf;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_25040118_ibuf #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ordy;
        logic        irdy;
        logic        ovld;
        logic [31:0] opc;
        logic [31:0] oinst;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'hdead_beef;
        in_inst   = 32'hdead_beef;
        out_ready = 1'b0;
    endtask

    initial begin
        logic exp_ovld;
        logic [31:0] exp_opc, exp_oinst;
        int pat[5];
        int sent, got, cyc;
        logic did_push;

        pat = '{1, 0, 1, 1, 0};

        //        fl  iv  pc            inst          ordy irdy ovld opc           oinst         cnt
        vecs[0]  = '{0, 1, 32'h8000_0000, 32'h0000_0093, 0, 1, 0, 32'h8000_0000, 32'h0000_0013, 3'd0};
        vecs[1]  = '{0, 1, 32'h8000_0004, 32'h0010_0113, 0, 1, 1, 32'h8000_0000, 32'h0000_0093, 3'd1};
        vecs[2]  = '{0, 1, 32'h8000_0008, 32'h0020_0193, 0, 1, 1, 32'h8000_0000, 32'h0000_0093, 3'd2};
        vecs[3]  = '{0, 1, 32'h8000_000c, 32'h0030_0213, 0, 1, 1, 32'h8000_0000, 32'h0000_0093, 3'd3};
        vecs[4]  = '{0, 1, 32'h8000_0010, 32'h0040_0293, 0, 0, 1, 32'h8000_0000, 32'h0000_0093, 3'd4};
        vecs[5]  = '{0, 1, 32'h8000_0010, 32'h0040_0293, 1, 0, 1, 32'h8000_0000, 32'h0000_0093, 3'd4};
        vecs[6]  = '{0, 1, 32'h8000_0010, 32'h0040_0293, 1, 1, 1, 32'h8000_0004, 32'h0010_0113, 3'd3};
        vecs[7]  = '{0, 0, 32'h0,         32'h0,         1, 1, 1, 32'h8000_0008, 32'h0020_0193, 3'd3};
        vecs[8]  = '{0, 0, 32'h0,         32'h0,         1, 1, 1, 32'h8000_000c, 32'h0030_0213, 3'd2};
        vecs[9]  = '{0, 0, 32'h0,         32'h0,         1, 1, 1, 32'h8000_0010, 32'h0040_0293, 3'd1};
        vecs[10] = '{0, 0, 32'h0,         32'h0,         0, 1, 0, 32'h8000_0000, 32'h0000_0013, 3'd0};
        vecs[11] = '{0, 1, 32'h8000_0200, 32'h0000_0011, 0, 1, 0, 32'h8000_0000, 32'h0000_0013, 3'd0};
        vecs[12] = '{0, 1, 32'h8000_0204, 32'h0000_0012, 0, 1, 1, 32'h8000_0200, 32'h0000_0011, 3'd1};
        vecs[13] = '{0, 1, 32'h8000_0208, 32'h0000_0222, 0, 1, 1, 32'h8000_0200, 32'h0000_0011, 3'd2};
        vecs[14] = '{1, 1, 32'h8000_0100, 32'h0000_dead, 1, 0, 0, 32'h8000_0200, 32'h0000_0011, 3'd3};
        vecs[15] = '{0, 0, 32'h0,         32'h0,         1, 1, 0, 32'h8000_0000, 32'h0000_0013, 3'd0};
        vecs[16] = '{1, 0, 32'h0,         32'h0,         1, 0, 0, 32'h8000_0000, 32'h0000_0013, 3'd0};
        vecs[17] = '{0, 0, 32'h0,         32'h0,         0, 1, 0, 32'h8000_0000, 32'h0000_0013, 3'd0};

        // reset held with fetch pushing
        rst = 1'b0;
        idle();
        in_valid = 1'b1;
        in_pc    = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_inst", out_inst, 32'h0000_0013);
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_count", 32'(count), 32'd0);

        // vector table: fill, full with out_ready, drain, flush
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_pc     = vecs[i].pc;
            in_inst   = vecs[i].inst;
            out_ready = vecs[i].ordy;
            exp_ovld  = vecs[i].ovld;
            exp_opc   = vecs[i].opc;
            exp_oinst = vecs[i].oinst;
`ifdef YSYX_25040118_IBUF_BYPASS_EN
            if (vecs[i].cnt == 3'd0 && vecs[i].iv && !vecs[i].fl) begin
                exp_ovld  = 1'b1;
                exp_opc   = vecs[i].pc;
                exp_oinst = vecs[i].inst;
            end
`endif
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].irdy));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(exp_ovld));
            chk($sformatf("v%0d_out_pc", i), out_pc, exp_opc);
            chk($sformatf("v%0d_out_inst", i), out_inst, exp_oinst);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
        end
        @(negedge clk);
        idle();

        // wrap-around stream with stalled decode
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 10 && cyc < 200) begin
            @(negedge clk);
            in_valid  = (sent < 10);
            in_pc     = 32'h8000_0000 + 32'(4 * sent);
            in_inst   = 32'h0000_5a00 + 32'(sent);
            out_ready = (pat[cyc % 5] == 1);
            #1;
            did_push = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("wrap_pc", out_pc, 32'h8000_0000 + 32'(4 * got));
                chk("wrap_inst", out_inst, 32'h0000_5a00 + 32'(got));
                got++;
            end
            if (did_push) sent++;
            cyc++;
        end
        chk("wrap_total", 32'(got), 32'd10);
        @(negedge clk);
        idle();
        #1;
        chk("wrap_end_count", 32'(count), 32'd0);

        // empty-path latency
        @(negedge clk);
        in_valid  = 1'b1;
        in_pc     = 32'h8000_0020;
        in_inst   = 32'h0000_0513;
        out_ready = 1'b1;
        #1;
`ifdef YSYX_25040118_IBUF_BYPASS_EN
        chk("byp_out_valid", 32'(out_valid), 32'd1);
        chk("byp_out_pc", out_pc, 32'h8000_0020);
        @(negedge clk);
        idle();
        #1;
        chk("byp_count", 32'(count), 32'd0);
        chk("byp_after_valid", 32'(out_valid), 32'd0);
`else
        chk("lat_out_valid0", 32'(out_valid), 32'd0);
        @(negedge clk);
        idle();
        out_ready = 1'b1;
        #1;
        chk("lat_out_valid1", 32'(out_valid), 32'd1);
        chk("lat_out_pc", out_pc, 32'h8000_0020);
        chk("lat_count", 32'(count), 32'd1);
        @(negedge clk);
        idle();
        #1;
        chk("lat_drained", 32'(count), 32'd0);
`endif

        // asynchronous reset with entries buffered
        @(negedge clk);
        in_valid = 1'b1;
        in_pc    = 32'h8000_0300;
        @(negedge clk);
        in_pc    = 32'h8000_0304;
        @(negedge clk);
        idle();
        #1;
        chk("ar_pre_count", 32'(count), 32'd2);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_out_pc", out_pc, 32'h8000_0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("ar_rel_in_ready", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25040118_ibuf.md
Name: ysyx_25040118_ibuf

Overview:
- Instruction buffer between the fetch stage and the decode stage.
- Captures {pc, inst} pairs from fetch into a DEPTH-entry FIFO and presents them to decode in program order over valid/ready handshakes.
- Decouples fetch from decode stalls.
- Discards all buffered instructions on a control-flow redirect (flush).

Parameters:
- DEPTH, 4: number of {pc, inst} entries. Power of two, >= 2.
- AW, 2: pointer index width. Must equal log2(DEPTH).

Ports:
- clk  input  1  system clock. All state updates on posedge.
- rst  input  1  asynchronous, active-low reset. rst=0 clears state immediately, independent of clk.
- flush  input  1  redirect from execute/branch. Empties the buffer.
- in_valid  input  1  fetch presents a valid {in_pc, in_inst}.
- in_ready  output  1  buffer can accept this cycle.
- in_pc  input  32  fetch PC.
- in_inst  input  32  fetched instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  head PC.
- out_inst  output  32  head instruction.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit array, read pointer rptr and write pointer wptr, each AW+1 bits. The extra MSB is a wrap bit.
  - empty = (rptr == wptr).
  - full = (index bits equal) and (wrap bits differ).
  - count = wptr - rptr, modulo 2^(AW+1).
- Reset (rst=0, asynchronous):
  - rptr = wptr = 0, so count = 0.
  - out_valid = 0, in_ready = 0 while rst=0.
  - out_pc = 0x80000000 and out_inst = 0x00000013 (NOP) while empty.
  - Array contents are don't-care.
  - Reset asserted mid-transfer drops every entry. No handshake completes in that cycle.
- Handshake definitions:
  - in_ready = !full && !flush.
  - push = in_valid && in_ready.
  - out_valid = !empty && !flush.
  - pop = out_valid && out_ready.
- Push: mem[wptr index] <= {in_pc, in_inst} and wptr += 1 at posedge.
- Pop: rptr += 1 at posedge.
- Simultaneous push and pop: both pointers advance and count is unchanged.
  - Allowed at any occupancy below full.
  - When full, in_ready = 0 even if out_ready = 1. There is no same-cycle pass-through while full.
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. 1-cycle minimum latency (base build).
- Output data:
  - out_pc and out_inst are driven combinationally from mem[rptr index] when !empty.
  - When empty they hold the reset values 0x80000000 / 0x00000013.
- Flush has priority over everything:
  - During a flush cycle, in_ready = 0 and out_valid = 0, so no push or pop occurs.
  - At the next posedge, rptr <= wptr and count becomes 0.
  - Flush while empty has no effect.
  - Flush held for several cycles keeps the buffer empty.
- Wrap-around: pointers wrap modulo 2^(AW+1). Ordering is preserved across wrap.
- Upstream data is sampled only on push. in_pc and in_inst are ignored otherwise.
- Decode must hold out_ready meaningfully only when out_valid=1. out_* remain stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: YSYX_25040118_IBUF_BYPASS_EN.
- Defined: when empty and not flushing, an incoming in_valid is forwarded combinationally:
  - out_valid = in_valid, out_pc = in_pc, out_inst = in_inst.
  - in_ready = 1 when empty and not flushing.
  - If out_ready=1 in that cycle, the pair is consumed without being written and the pointers are unchanged.
  - If out_ready=0, it is written normally.
  - This gives zero-cycle latency on the empty path.
- Undefined: behaviour exactly as in Behaviour, with 1-cycle minimum latency.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=0, out_inst=0x00000013. Release rst -> in_ready=1 on the next cycle.
- Fill and drain: out_ready=0, push PCs 0x80000000/04/08/0C with insts 0x00000093/0x00100113/0x00200193/0x00300213 -> count=4, in_ready=0. Then out_ready=1 for 4 cycles -> same four pairs appear in order, count ends at 0.
- Full with simultaneous out_ready: buffer full, in_valid=1, out_ready=1 -> one pop, no push, count=3. Next cycle push and pop both occur -> count stays 3.
- Flush: 3 entries buffered, assert flush with in_valid=1 (pc 0x80000100) -> out_valid=0 and in_ready=0 that cycle, count=0 after the edge, pc 0x80000100 never appears on the output.
- Wrap-around: stream 10 sequential PCs from 0x80000000 step 4, with out_ready toggling 1,0,1,1,0 repeating -> all 10 PCs emitted exactly once in order, no gaps or duplicates.
- Bypass (macro defined): buffer empty, in_valid=1 pc 0x80000020, out_ready=1 -> out_valid=1 with out_pc=0x80000020 in the same cycle, count stays 0. Macro undefined -> it appears one cycle later.
